joy_cursor_ctrl: RTL

Parametrised joystick-to-cursor position controller. It is the successor to the fixed-function cursor updater and drives the VGA cursor overlay.
- Converts two ADC joystick readings into clamped X/Y cursor coordinates, one move per rising edge of a slow cursor tick.
- Adds configurable thresholds and polarity, saturating bounds, hold-to-accelerate, a home command, an enable and edge/motion status.

---
 rtl/joy_pkg.sv | 16 +
 rtl/joy_cursor_ctrl_if.sv | 20 ++
 rtl/joy_axis.sv | 119 +++++++++++
 rtl/joy_cursor_ctrl.sv | 77 +++++++
 4 files changed

// File: rtl/joy_pkg.sv
// Shared types and default tuning constants for the joystick cursor controller.
package joy_pkg;

   typedef enum logic [1:0] {DIR_NONE, DIR_NEG, DIR_POS} dir_t;
   typedef enum logic [1:0] {SPD_SLOW, SPD_FAST, SPD_ACCEL} spd_t;

   localparam int LO_FAST_DEF     = 150;
   localparam int LO_SLOW_DEF     = 400;
   localparam int HI_SLOW_DEF     = 600;
   localparam int HI_FAST_DEF     = 850;
   localparam int STEP_SLOW_DEF   = 10;
   localparam int STEP_FAST_DEF   = 20;
   localparam int STEP_ACCEL_DEF  = 40;
   localparam int ACCEL_TICKS_DEF = 8;

endpackage

// File: rtl/joy_cursor_ctrl_if.sv
// Joystick/cursor bus: controls and ADC samples in, cursor position and status out.
interface joy_cursor_ctrl_if #(
   parameter int W     = 10,
   parameter int ADC_W = 10
);
   logic             tick;
   logic             en;
   logic             home;
   logic [ADC_W-1:0] joy_x;
   logic [ADC_W-1:0] joy_y;
   logic [W-1:0]     dot_x;
   logic [W-1:0]     dot_y;
   logic             moving;
   logic [3:0]       at_edge;

   modport master (output tick, en, home, joy_x, joy_y,
                   input  dot_x, dot_y, moving, at_edge);
   modport slave  (input  tick, en, home, joy_x, joy_y,
                   output dot_x, dot_y, moving, at_edge);
endinterface

// File: rtl/joy_axis.sv
// One cursor axis: deflection classifier, hold/acceleration counter, step select
// and saturating position update.
module joy_axis
   import joy_pkg::*;
#(
   parameter int W           = 10,
   parameter int ADC_W       = 10,
   parameter int MIN         = 566,
   parameter int MAX         = 689,
   parameter int INIT        = 627,
   parameter bit POL         = 1'b1,
   parameter int LO_FAST     = LO_FAST_DEF,
   parameter int LO_SLOW     = LO_SLOW_DEF,
   parameter int HI_SLOW     = HI_SLOW_DEF,
   parameter int HI_FAST     = HI_FAST_DEF,
   parameter int STEP_SLOW   = STEP_SLOW_DEF,
   parameter int STEP_FAST   = STEP_FAST_DEF,
   parameter int STEP_ACCEL  = STEP_ACCEL_DEF,
   parameter int ACCEL_TICKS = ACCEL_TICKS_DEF
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             step_evt,
   input  logic             home,
   input  logic             en,
   input  logic [ADC_W-1:0] joy,
   output logic [W-1:0]     pos,
   output logic             changed
);

   localparam logic [ADC_W-1:0]  LO_FAST_J = ADC_W'(LO_FAST);
   localparam logic [ADC_W-1:0]  LO_SLOW_J = ADC_W'(LO_SLOW);
   localparam logic [ADC_W-1:0]  HI_SLOW_J = ADC_W'(HI_SLOW);
   localparam logic [ADC_W-1:0]  HI_FAST_J = ADC_W'(HI_FAST);
   localparam logic signed [W+1:0] MIN_S  = (W+2)'(MIN);
   localparam logic signed [W+1:0] MAX_S  = (W+2)'(MAX);
   localparam logic [W-1:0]      INIT_P    = W'(INIT);
   localparam logic [7:0]        ACCEL_N   = 8'(ACCEL_TICKS);

   dir_t                dir, last_dir;
   spd_t                spd;
   logic                low, high, fast, reversal;
   logic [7:0]          hold_cnt, hold_nxt;
   logic signed [W+1:0] pos_s, step_s, sum_s, clamp_s;
   logic [W-1:0]        pos_nxt;

   // NOTE: every variable gets a default at the top of the block so no latch is inferred.
   always_comb begin
      low  = 1'b0;
      high = 1'b0;
      fast = 1'b0;
      dir  = DIR_NONE;
      if (joy < LO_FAST_J) begin
         low  = 1'b1;
         fast = 1'b1;
      end else if (joy < LO_SLOW_J) begin
         low  = 1'b1;
      end else if (joy > HI_FAST_J) begin
         high = 1'b1;
         fast = 1'b1;
      end else if (joy > HI_SLOW_J) begin
         high = 1'b1;
      end
      if (low)       dir = POL ? DIR_POS : DIR_NEG;
      else if (high) dir = POL ? DIR_NEG : DIR_POS;
   end

   // A reversal is only meaningful against a remembered direction of travel.
   assign reversal = (last_dir != DIR_NONE) && (dir != DIR_NONE) && (dir != last_dir);

   always_comb begin
      spd = SPD_SLOW;
      if (fast) spd = (!reversal && hold_cnt == ACCEL_N) ? SPD_ACCEL : SPD_FAST;
      hold_nxt = 8'd0;
      if (fast && !reversal) hold_nxt = (hold_cnt == ACCEL_N) ? hold_cnt : hold_cnt + 8'd1;
   end

   always_comb begin
      case (spd)
         SPD_FAST:  step_s = (W+2)'(STEP_FAST);
         SPD_ACCEL: step_s = (W+2)'(STEP_ACCEL);
         default:   step_s = (W+2)'(STEP_SLOW);
      endcase
      pos_s = signed'({2'b00, pos});
      case (dir)
         DIR_POS: sum_s = pos_s + step_s;
         DIR_NEG: sum_s = pos_s - step_s;
         default: sum_s = pos_s;
      endcase
      if (sum_s > MAX_S)      clamp_s = MAX_S;
      else if (sum_s < MIN_S) clamp_s = MIN_S;
      else                    clamp_s = sum_s;

      if (home)                 pos_nxt = INIT_P;
      else if (step_evt && en)  pos_nxt = clamp_s[W-1:0];
      else                      pos_nxt = pos;
   end

   assign changed = (pos_nxt != pos);

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (clr) begin
         pos      <= INIT_P;
         hold_cnt <= 8'd0;
         last_dir <= DIR_NONE;
      end else begin
         pos <= pos_nxt;
         if (home || (step_evt && !en)) begin
            hold_cnt <= 8'd0;
            last_dir <= DIR_NONE;
         end else if (step_evt) begin
            hold_cnt <= hold_nxt;
            last_dir <= dir;
         end
      end
   end

endmodule

// File: rtl/joy_cursor_ctrl.sv
// Joystick-to-cursor controller: tick edge detection, two independent axes,
// motion flag and bound status.
module joy_cursor_ctrl
   import joy_pkg::*;
#(
   parameter int W           = 10,
   parameter int ADC_W       = 10,
   parameter int X_MIN       = 566,
   parameter int X_MAX       = 689,
   parameter int Y_MIN       = 116,
   parameter int Y_MAX       = 426,
   parameter int INIT_X      = 627,
   parameter int INIT_Y      = 271,
   parameter int LO_FAST     = LO_FAST_DEF,
   parameter int LO_SLOW     = LO_SLOW_DEF,
   parameter int HI_SLOW     = HI_SLOW_DEF,
   parameter int HI_FAST     = HI_FAST_DEF,
   parameter int STEP_SLOW   = STEP_SLOW_DEF,
   parameter int STEP_FAST   = STEP_FAST_DEF,
   parameter int STEP_ACCEL  = STEP_ACCEL_DEF,
   parameter int ACCEL_TICKS = ACCEL_TICKS_DEF,
   parameter bit X_POL       = 1'b1,
   parameter bit Y_POL       = 1'b0
) (
   input logic               clk,
   input logic               clr,
   joy_cursor_ctrl_if.slave  bus
);

   localparam logic [W-1:0] X_MIN_P = W'(X_MIN);
   localparam logic [W-1:0] X_MAX_P = W'(X_MAX);
   localparam logic [W-1:0] Y_MIN_P = W'(Y_MIN);
   localparam logic [W-1:0] Y_MAX_P = W'(Y_MAX);

   logic         tick_q, step_evt, moving_q;
   logic         x_changed, y_changed;
   logic [W-1:0] x_pos, y_pos;

   // One step per rising edge of tick, however long it stays high.
   assign step_evt = bus.tick & ~tick_q;

   always_ff @(posedge clk) begin
      if (clr) begin
         tick_q   <= 1'b0;
         moving_q <= 1'b0;
      end else begin
         tick_q   <= bus.tick;
         moving_q <= x_changed | y_changed;
      end
   end

   joy_axis #(
      .W(W), .ADC_W(ADC_W), .MIN(X_MIN), .MAX(X_MAX), .INIT(INIT_X), .POL(X_POL),
      .LO_FAST(LO_FAST), .LO_SLOW(LO_SLOW), .HI_SLOW(HI_SLOW), .HI_FAST(HI_FAST),
      .STEP_SLOW(STEP_SLOW), .STEP_FAST(STEP_FAST), .STEP_ACCEL(STEP_ACCEL),
      .ACCEL_TICKS(ACCEL_TICKS)
   ) u_axis_x (
      .clk(clk), .clr(clr), .step_evt(step_evt), .home(bus.home), .en(bus.en),
      .joy(bus.joy_x), .pos(x_pos), .changed(x_changed)
   );

   joy_axis #(
      .W(W), .ADC_W(ADC_W), .MIN(Y_MIN), .MAX(Y_MAX), .INIT(INIT_Y), .POL(Y_POL),
      .LO_FAST(LO_FAST), .LO_SLOW(LO_SLOW), .HI_SLOW(HI_SLOW), .HI_FAST(HI_FAST),
      .STEP_SLOW(STEP_SLOW), .STEP_FAST(STEP_FAST), .STEP_ACCEL(STEP_ACCEL),
      .ACCEL_TICKS(ACCEL_TICKS)
   ) u_axis_y (
      .clk(clk), .clr(clr), .step_evt(step_evt), .home(bus.home), .en(bus.en),
      .joy(bus.joy_y), .pos(y_pos), .changed(y_changed)
   );

   assign bus.dot_x   = x_pos;
   assign bus.dot_y   = y_pos;
   assign bus.moving  = moving_q;
   assign bus.at_edge = {y_pos == Y_MAX_P, y_pos == Y_MIN_P, x_pos == X_MAX_P, x_pos == X_MIN_P};

endmodule
